// File: rtl/sprite_evaluator.sv
// OAM scan for one scanline: copies up to MAX_SPRITES visible entries into the secondary buffer.
// Define SPRITE_VFLIP_EN to mirror the sprite row when OAM word bit 31 (vflip) is set.
module sprite_evaluator #(
    parameter int unsigned NUM_ENTRIES = 64,
    parameter int unsigned MAX_SPRITES = 8,
    parameter int unsigned SPRITE_H    = 16,
    parameter int unsigned Y_W         = 9
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [Y_W-1:0]                     line,
    output logic                               busy,
    output logic                               done,
    output logic                               oam_re,
    output logic [$clog2(NUM_ENTRIES)-1:0]     oam_addr,
    input  logic [31:0]                        oam_rdata,
    output logic                               sec_we,
    output logic [$clog2(MAX_SPRITES)-1:0]     sec_addr,
    output logic [31:0]                        sec_data,
    output logic [$clog2(SPRITE_H)-1:0]        sec_row,
    output logic [$clog2(MAX_SPRITES+1)-1:0]   sprite_count,
    output logic                               overflow
);

    localparam int unsigned AW = $clog2(NUM_ENTRIES);
    localparam int unsigned SW = $clog2(MAX_SPRITES);
    localparam int unsigned RW = $clog2(SPRITE_H);
    localparam int unsigned CW = $clog2(MAX_SPRITES + 1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [Y_W-1:0]  line_q, line_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            eval_q, eval_d;
    logic            sec_we_q, sec_we_d;
    logic [SW-1:0]   sec_addr_q, sec_addr_d;
    logic [31:0]     sec_data_q, sec_data_d;
    logic [RW-1:0]   sec_row_q, sec_row_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [Y_W:0]    diff;
    logic            hit;
    logic            evaluate;
    logic [RW-1:0]   row;

`ifdef SPRITE_VFLIP_EN
    localparam logic [RW-1:0] RowMax = RW'(SPRITE_H - 1);
`endif

    always_comb begin
        // A borrow out of the Y_W+1-bit subtraction means the sprite starts below the line.
        diff = {1'b0, line_q} - {1'b0, oam_rdata[Y_W-1:0]};
        hit  = !diff[Y_W] && (diff[Y_W-1:0] < Y_W'(SPRITE_H));
`ifdef SPRITE_VFLIP_EN
        row  = oam_rdata[31] ? (RowMax - diff[RW-1:0]) : diff[RW-1:0];
`else
        row  = diff[RW-1:0];
`endif
        // Read data is only meaningful the cycle after a SCAN cycle, and never once terminated.
        evaluate = eval_q && ((state_q == StScan) || (state_q == StDrain));
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        addr_d     = addr_q;
        eval_d     = 1'b0;
        sec_we_d   = 1'b0;
        sec_addr_d = sec_addr_q;
        sec_data_d = sec_data_q;
        sec_row_d  = sec_row_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    line_d  = line;
                    addr_d  = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            StScan: begin
                addr_d = addr_q + AW'(1);
                eval_d = 1'b1;
                if (addr_q == AW'(NUM_ENTRIES - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (evaluate && hit) begin
            if (count_q < CW'(MAX_SPRITES)) begin
                sec_we_d   = 1'b1;
                sec_addr_d = count_q[SW-1:0];
                sec_data_d = oam_rdata;
                sec_row_d  = row;
                count_d    = count_q + CW'(1);
            end else begin
                ovf_d   = 1'b1;
                state_d = StDone;
                eval_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            line_q     <= '0;
            addr_q     <= '0;
            eval_q     <= 1'b0;
            sec_we_q   <= 1'b0;
            sec_addr_q <= '0;
            sec_data_q <= '0;
            sec_row_q  <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
            eval_q     <= eval_d;
            sec_we_q   <= sec_we_d;
            sec_addr_q <= sec_addr_d;
            sec_data_q <= sec_data_d;
            sec_row_q  <= sec_row_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        busy         = (state_q == StScan) || (state_q == StDrain);
        done         = (state_q == StDone);
        oam_re       = (state_q == StScan);
        oam_addr     = addr_q;
        sec_we       = sec_we_q;
        sec_addr     = sec_addr_q;
        sec_data     = sec_data_q;
        sec_row      = sec_row_q;
        sprite_count = count_q;
        overflow     = ovf_q;
    end

endmodule

// File: tb/tb_sprite_evaluator.sv
// Bench for sprite_evaluator: randomized OAM contents checked against a list-based line model.
module tb_sprite_evaluator;

    localparam int NE = 64;
    localparam int MS = 8;
    localparam int SH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  line;
    logic        busy, done, oam_re;
    logic [5:0]  oam_addr;
    logic [31:0] oam_rdata;
    logic        sec_we;
    logic [2:0]  sec_addr;
    logic [31:0] sec_data;
    logic [3:0]  sec_row;
    logic [3:0]  sprite_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    sprite_evaluator #(
        .NUM_ENTRIES(NE),
        .MAX_SPRITES(MS),
        .SPRITE_H   (SH),
        .Y_W        (9)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .line        (line),
        .busy        (busy),
        .done        (done),
        .oam_re      (oam_re),
        .oam_addr    (oam_addr),
        .oam_rdata   (oam_rdata),
        .sec_we      (sec_we),
        .sec_addr    (sec_addr),
        .sec_data    (sec_data),
        .sec_row     (sec_row),
        .sprite_count(sprite_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    logic [31:0] oam [NE];
    initial oam_rdata = 32'h0;
    always @(posedge clk) if (oam_re) oam_rdata <= oam[oam_addr];

    logic [2:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  wr_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (sec_we) begin
                wa_q.push_back(sec_addr);
                wd_q.push_back(sec_data);
                wr_q.push_back(sec_row);
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [8:0] y);
        logic [31:0] r;
        r = $urandom;
        return {r[31:9], y};
    endfunction

    task automatic fill_all(input logic [8:0] y);
        for (int i = 0; i < NE; i++) oam[i] = mk(y);
    endtask

    // Model: walk the entries in order, collect hits, stop at the first hit beyond MS.
    task automatic run_scan(input logic [8:0] ln, input int pulse_at, input bit start_in_done,
                            input string tag);
        logic [31:0] ed[$];
        int          er[$];
        int          hits;
        int          ovf_idx;
        int          exp_cyc;
        int          n;
        int          base;
        int          nw;
        hits    = 0;
        ovf_idx = -1;
        for (int i = 0; i < NE; i++) begin
            int d;
            int r;
            d = int'(ln) - int'(oam[i][8:0]);
            if (d >= 0 && d < SH && ovf_idx < 0) begin
                if (hits < MS) begin
                    r = d;
`ifdef SPRITE_VFLIP_EN
                    if (oam[i][31]) r = SH - 1 - d;
`endif
                    ed.push_back(oam[i]);
                    er.push_back(r);
                end else begin
                    ovf_idx = i;
                end
                hits++;
            end
        end
        exp_cyc = (ovf_idx >= 0) ? ovf_idx + 3 : NE + 2;

        wa_q.delete();
        wd_q.delete();
        wr_q.delete();
        base = done_cnt;

        @(negedge clk);
        start = 1'b1;
        line  = ln;
        @(negedge clk);
        start = 1'b0;
        line  = 9'($urandom);
        n = 1;
        chk({tag, ":busy_c1"}, 64'(busy), 64'd1);
        chk({tag, ":addr_c1"}, 64'(oam_addr), 64'd0);
        while (done !== 1'b1 && n < 200) begin
            start = (n == pulse_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, ":done_cycle"}, 64'(n), 64'(exp_cyc));
        chk({tag, ":busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, ":re_at_done"}, 64'(oam_re), 64'd0);
        if (start_in_done) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ":done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, ":busy_after"}, 64'(busy), 64'd0);
        chk({tag, ":count"}, 64'(sprite_count), 64'(ed.size()));
        chk({tag, ":overflow"}, 64'(overflow), 64'(ovf_idx >= 0));
        chk({tag, ":done_pulses"}, 64'(done_cnt - base), 64'd1);
        chk({tag, ":nwrites"}, 64'(wa_q.size()), 64'(ed.size()));
        nw = (wa_q.size() < ed.size()) ? wa_q.size() : ed.size();
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("%s:slot%0d", tag, i), 64'(wa_q[i]), 64'(i));
            chk($sformatf("%s:data%0d", tag, i), 64'(wd_q[i]), 64'(ed[i]));
            chk($sformatf("%s:row%0d", tag, i), 64'(wr_q[i]), 64'(er[i]));
        end
        @(negedge clk);
    endtask

    initial begin
        int base;
        reset = 1'b0;
        start = 1'b0;
        line  = 9'd0;
        fill_all(9'd400);

        repeat (3) @(negedge clk);
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:done", 64'(done), 64'd0);
        chk("rst:oam_re", 64'(oam_re), 64'd0);
        chk("rst:oam_addr", 64'(oam_addr), 64'd0);
        chk("rst:sec_we", 64'(sec_we), 64'd0);
        chk("rst:sec_addr", 64'(sec_addr), 64'd0);
        chk("rst:sec_data", 64'(sec_data), 64'd0);
        chk("rst:sec_row", 64'(sec_row), 64'd0);
        chk("rst:count", 64'(sprite_count), 64'd0);
        chk("rst:overflow", 64'(overflow), 64'd0);
        reset = 1'b1;

        // Two hits at entries 3 and 10, with an ignored start mid-scan.
        fill_all(9'd400);
        oam[3]  = mk(9'd100);
        oam[10] = mk(9'd100);
        run_scan(9'd105, 20, 1'b0, "two_hits");

        // Nine hits: early termination at the ninth.
        fill_all(9'd400);
        for (int i = 0; i < 9; i++) oam[i] = mk(9'd50);
        run_scan(9'd60, -1, 1'b1, "overflow");

        fill_all(9'd400);
        oam[7] = mk(9'd100);
        run_scan(9'd100, -1, 1'b0, "bnd_top");
        run_scan(9'd115, -1, 1'b0, "bnd_bottom");
        run_scan(9'd116, -1, 1'b0, "bnd_miss");
        oam[7] = mk(9'd470);
        run_scan(9'd5, -1, 1'b0, "no_wrap");
        fill_all(9'd400);
        oam[0] = mk(9'd0);
        run_scan(9'd0, -1, 1'b0, "y_zero");

        fill_all(9'd400);
        oam[2] = mk(9'd100) | 32'h8000_0000;
        run_scan(9'd105, -1, 1'b0, "vflip");
`ifdef SPRITE_VFLIP_EN
        chk("vflip:row_direct", 64'(sec_row), 64'd10);
`else
        chk("vflip:row_direct", 64'(sec_row), 64'd5);
`endif

        for (int t = 0; t < 6; t++) begin
            logic [8:0] ln;
            ln = 9'($urandom_range(20, 80));
            for (int i = 0; i < NE; i++)
                oam[i] = mk(($urandom_range(0, t + 1) == 0) ? 9'($urandom_range(0, 100)) : 9'd400);
            run_scan(ln, -1, 1'b0, $sformatf("rand%0d", t));
        end

        // Reset mid-scan: immediate idle, no done; then a clean full scan.
        fill_all(9'd400);
        oam[3]  = mk(9'd100);
        oam[10] = mk(9'd100);
        @(negedge clk);
        start = 1'b1;
        line  = 9'd105;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        base  = done_cnt;
        reset = 1'b0;
        #1;
        chk("midrst:busy", 64'(busy), 64'd0);
        chk("midrst:oam_re", 64'(oam_re), 64'd0);
        chk("midrst:done", 64'(done), 64'd0);
        chk("midrst:count", 64'(sprite_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        chk("midrst:no_done", 64'(done_cnt - base), 64'd0);
        run_scan(9'd105, -1, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
